// File: rtl/acfir_rb_collector.sv
// ACFIR redundant-product collector: captures the final Mn2/Mp/Mpp
// accumulator, converts to scaled saturated binary, and queues it.
module acfir_rb_collector #(
  parameter int OUT_W = 16,
  parameter int SHIFT = 0,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              cnt,
  input  logic [7:0]              Mn2,
  input  logic [7:0]              Mp,
  input  logic [7:0]              Mpp,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sat,
  output logic                    ovf
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam int signed MAXV = (1 <<< (OUT_W - 1)) - 1;
  localparam int signed MINV = -(1 <<< (OUT_W - 1));

  logic [7:0] mn2_q, mp_q, mpp_q;
  logic       cap_v;

  logic [OUT_W:0]  mem [DEPTH];
  logic [OUT_W:0]  last_q;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;

  function automatic logic [15:0] spread(input logic [7:0] b);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[2*i] = b[i];
    return r;
  endfunction

  logic [17:0]        a, n;
  logic signed [17:0] v, vs;
  logic signed [31:0] vx;
  logic [OUT_W-1:0]   y;
  logic               sat_bit;

  always_comb begin
    a  = {2'b00, spread(mp_q)} + {2'b00, spread(mpp_q)};
    n  = {1'b0, spread(mn2_q), 1'b0};
    v  = signed'(a - n);
    vs = v >>> SHIFT;
    vx = {{14{vs[17]}}, vs};
    y = vx[OUT_W-1:0];
    sat_bit = 1'b0;
    if (vx > MAXV) begin
      y = OUT_W'(MAXV);
      sat_bit = 1'b1;
    end else if (vx < MINV) begin
      y = OUT_W'(MINV);
      sat_bit = 1'b1;
    end
  end

  logic [OUT_W:0] head;
  logic           full, pop, do_push;

  assign head      = mem[rd_ptr];
  assign out_valid = (count != '0);
  assign full      = (count == FULL_C);
  assign pop       = out_valid && out_ready;
  // a full FIFO still accepts a push when the same edge frees a slot
  assign do_push   = cap_v && (!full || pop);
  assign out_data  = out_valid ? head[OUT_W-1:0] : last_q[OUT_W-1:0];
  assign sat       = out_valid ? head[OUT_W] : last_q[OUT_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mn2_q  <= '0;
      mp_q   <= '0;
      mpp_q  <= '0;
      cap_v  <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
      ovf    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      cap_v <= (cnt == 3'd7);
      if (cnt == 3'd7) begin
        mn2_q <= Mn2;
        mp_q  <= Mp;
        mpp_q <= Mpp;
      end
      if (pop) begin
        last_q <= head;
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (do_push) begin
        mem[wr_ptr] <= {sat_bit, y};
        wr_ptr      <= wr_ptr + PW'(1);
      end else if (cap_v) begin
        ovf <= 1'b1;
      end
      if (do_push && !pop)
        count <= count + CW'(1);
      else if (!do_push && pop)
        count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_acfir_rb_collector.sv
// Directed bench for acfir_rb_collector: SHIFT=0 and SHIFT=2 instances
// share stimulus; expected values are hand-computed.
module tb_acfir_rb_collector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  cnt = 3'd0;
  logic [7:0]  Mn2 = 8'd0, Mp = 8'd0, Mpp = 8'd0;
  logic        out_ready = 1'b1;

  logic [15:0] d1, d2;
  logic        v1, v2, s1, s2, o1, o2;

  int total = 0;
  int bad = 0;

  acfir_rb_collector #(.OUT_W(16), .SHIFT(0), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .cnt(cnt), .Mn2(Mn2), .Mp(Mp), .Mpp(Mpp),
    .out_data(d1), .out_valid(v1), .out_ready(out_ready),
    .sat(s1), .ovf(o1)
  );

  acfir_rb_collector #(.OUT_W(16), .SHIFT(2), .DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .cnt(cnt), .Mn2(Mn2), .Mp(Mp), .Mpp(Mpp),
    .out_data(d2), .out_valid(v2), .out_ready(out_ready),
    .sat(s2), .ovf(o2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drive one cnt==7 cycle; returns just after the capture edge
  task automatic cap(input logic [7:0] p, input logic [7:0] pp,
                     input logic [7:0] m);
    Mp = p; Mpp = pp; Mn2 = m; cnt = 3'd7;
    tick();
    cnt = 3'd0; Mp = 8'd0; Mpp = 8'd0; Mn2 = 8'd0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // capture then push with out_ready=1; checks the pushed head
  task automatic one(input string tag, input logic [7:0] p,
                     input logic [7:0] pp, input logic [7:0] m,
                     input logic [15:0] e1, input logic es1,
                     input logic [15:0] e2, input logic es2);
    cap(p, pp, m);
    chk({tag, "_pre_valid"}, 32'(v1), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(v1), 32'd1);
    chk({tag, "_data"}, 32'(d1), 32'(e1));
    chk({tag, "_sat"}, 32'(s1), 32'(es1));
    chk({tag, "_data_sh2"}, 32'(d2), 32'(e2));
    chk({tag, "_sat_sh2"}, 32'(s2), 32'(es2));
    tick();
    chk({tag, "_popped"}, 32'(v1), 32'd0);
    chk({tag, "_hold"}, 32'(d1), 32'(e1));
  endtask

  initial begin
    idle(2);
    chk("rst_valid", 32'(v1), 32'd0);
    chk("rst_data", 32'(d1), 32'd0);
    chk("rst_sat", 32'(s1), 32'd0);
    chk("rst_ovf", 32'(o1), 32'd0);
    rst = 1'b0;
    idle(2);

    out_ready = 1'b1;
    one("p1",   8'h01, 8'h00, 8'h00, 16'd1,     1'b0, 16'd0,     1'b0);
    one("n2",   8'h00, 8'h00, 8'h01, 16'hFFFE,  1'b0, 16'hFFFF,  1'b0);
    one("mix",  8'h80, 8'h80, 8'h40, 16'd24576, 1'b0, 16'd6144,  1'b0);
    one("max",  8'hFF, 8'hFF, 8'h00, 16'd32767, 1'b1, 16'd10922, 1'b0);
    one("min",  8'h00, 8'h00, 8'hFF, 16'h8000,  1'b1, 16'hD555,  1'b0);

    // full FIFO with a pop on the push edge
    out_ready = 1'b0;
    cap(8'h01, 8'h00, 8'h00); idle(7);
    cap(8'h01, 8'h01, 8'h00); idle(7);
    chk("fp_head", 32'(d1), 32'd1);
    cap(8'h02, 8'h00, 8'h00);
    out_ready = 1'b1;
    tick();
    chk("fp_ovf", 32'(o1), 32'd0);
    chk("fp_d0", 32'(d1), 32'd2);
    tick();
    chk("fp_d1", 32'(d1), 32'd4);
    chk("fp_v1", 32'(v1), 32'd1);
    tick();
    chk("fp_empty", 32'(v1), 32'd0);
    chk("fp_ovf2", 32'(o1), 32'd0);

    // cnt==7 held two cycles yields two results
    out_ready = 1'b0;
    Mp = 8'h01; cnt = 3'd7; tick();
    Mp = 8'h02; tick();
    cnt = 3'd0; Mp = 8'h00; tick();
    chk("c7_head", 32'(d1), 32'd1);
    out_ready = 1'b1; tick();
    chk("c7_next", 32'(d1), 32'd4);
    tick();
    chk("c7_empty", 32'(v1), 32'd0);

    // overflow: third result dropped
    out_ready = 1'b0;
    cap(8'h01, 8'h00, 8'h00); idle(7);
    chk("of_ovf0", 32'(o1), 32'd0);
    cap(8'h01, 8'h01, 8'h00); idle(7);
    cap(8'h02, 8'h00, 8'h00); idle(7);
    chk("of_ovf", 32'(o1), 32'd1);
    chk("of_head", 32'(d1), 32'd1);
    chk("of_valid", 32'(v1), 32'd1);
    out_ready = 1'b1; tick();
    chk("of_second", 32'(d1), 32'd2);
    chk("of_valid2", 32'(v1), 32'd1);
    tick();
    chk("of_empty", 32'(v1), 32'd0);
    chk("of_hold", 32'(d1), 32'd2);
    chk("of_sticky", 32'(o1), 32'd1);

    // async reset between capture and push
    out_ready = 1'b0;
    cap(8'h01, 8'h00, 8'h00); tick();
    chk("ar_pre", 32'(v1), 32'd1);
    cap(8'h01, 8'h01, 8'h00);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", 32'(v1), 32'd0);
    chk("ar_ovf", 32'(o1), 32'd0);
    chk("ar_data", 32'(d1), 32'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    idle(4);
    chk("ar_none", 32'(v1), 32'd0);
    chk("ar_none2", 32'(v2), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acfir_rb_collector.md
Name: acfir_rb_collector

Overview:
- Sits directly downstream of the radix-4 hybrid redundant serial multiplier in the ACFIR stream processor.
- Watches the multiplier's 3-bit cycle counter and captures the final redundant accumulator (Mn2/Mp/Mpp) on the last cycle of each 8-cycle product.
- Converts that value to two's-complement binary, scales and saturates it, and buffers it in a small FIFO.
- Presents the result on a valid/ready stream to the FIR adder tree.

Parameters:
- OUT_W, 16, output sample width (signed), 8..18.
- SHIFT, 0, arithmetic right shift applied before saturation, 0..8.
- DEPTH, 2, output FIFO depth, power of 2, 2..8.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cnt  in  3  multiplier digit counter; value 7 marks the last accumulation cycle.
- Mn2  in  8  redundant digit component, weight -2*4^i.
- Mp  in  8  redundant digit component, weight +1*4^i.
- Mpp  in  8  redundant digit component, weight +1*4^i.
- out_data  out  OUT_W  signed product sample.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  downstream accept.
- sat  out  1  saturation flag travelling with out_data (FIFO-stored).
- ovf  out  1  sticky: a result was dropped because the FIFO was full.

Behaviour:
- Reset (async, rst=1): capture regs, capture-valid, FIFO pointers/count, ovf all cleared. out_valid=0, out_data=0, sat=0. Reset mid-operation discards any in-flight capture and all FIFO contents.
- Digit value at position i: d_i = Mp[i] + Mpp[i] - 2*Mn2[i], range -2..+2.
- Product value: V = sum over i=0..7 of d_i*4^i.
- Stage 0 (capture): on an edge sampling cnt==7, Mn2/Mp/Mpp are registered and cap_v is set for one cycle. It is cleared on every other edge. Back-to-back captures every 8 cycles are supported.
- Stage 1 (convert): when cap_v=1, the next edge computes the following and pushes {Y, sat_bit} into the FIFO.
  - A = spread(Mp) + spread(Mpp), where spread places bit i at bit 2i, 16-bit unsigned.
  - N = spread(Mn2) << 1.
  - V = A - N, 18-bit signed; range -43690..+43690, so no internal overflow.
  - Vs = V >>> SHIFT (arithmetic, truncation toward -inf).
  - Y = Vs saturated to signed OUT_W. sat_bit=1 iff clamping occurred.
- Latency: edge E0 samples cnt==7; push occurs at E1; out_valid=1 after E1 if the FIFO was empty (2 cycles).
- FIFO is first-word-fall-through. out_data/sat show the head entry when out_valid=1, and hold the last popped value (0 after reset) otherwise.
- Pop on an edge with out_valid && out_ready.
- Push when full without a same-edge pop: the new result is dropped, contents are unchanged, ovf is set to 1 and stays 1 until reset.
- Push and pop on the same edge with the FIFO full: both happen, no drop, count unchanged.
- Push and pop on the same edge with the FIFO empty cannot occur, since out_valid is 0. The entry becomes visible the next cycle.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- cnt values other than 7 are ignored. A cnt==7 held for consecutive cycles captures each cycle; this is legal and each capture yields one result.

Test Plan:
- Mp=0x01, Mpp=0, Mn2=0, cnt==7 at E0, out_ready=1 -> out_valid at E1, out_data=1, sat=0; popped at E2.
- Mn2=0x01, others 0 -> out_data=-2 (0xFFFE); Mp=Mpp=0x80, Mn2=0x40 -> V=2*16384-2*4096=24576.
- Mp=Mpp=0xFF, Mn2=0 (V=43690), OUT_W=16 -> out_data=32767, sat=1; Mn2=0xFF, others 0 -> out_data=-32768, sat=1; with SHIFT=2 -> 10922 and -10923, sat=0.
- out_ready=0, three captures 8 cycles apart, DEPTH=2 -> first two held in order, third dropped, ovf=1 persists; then out_ready=1 -> two pops, out_valid falls.
- FIFO full, out_ready=1 on the push edge -> no drop, ovf stays 0, order preserved.
- rst asserted asynchronously between capture and push -> out_valid=0 and ovf=0 immediately, no result ever emitted for that capture.
